// File: rtl/spi_flash_resp.sv
// spi_flash_resp: SPI-flash target model (mode 0) that serves READ (0x03) and
// JEDEC-ID (0x9F). The SPI pins are oversampled in the clk_i domain. Read data
// comes from a byte-wide memory port through a one-byte prefetch buffer.
module spi_flash_resp #(
  parameter int          MEM_AW      = 12,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_clk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic              cmd_err_o,
  output logic              underrun_o
);

  // The receive shifter only keeps the bits that are ever used: the command
  // byte, or the low MEM_AW address bits. Upper address bits fall off the end.
  localparam int RXW = (MEM_AW > 8) ? MEM_AW - 1 : 7;
  localparam logic [MEM_AW-1:0] ADDR_ONE = 1;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_q;
  logic                   sck_s, cs_s, mosi_s, sck_rise, sck_fall;

  logic [4:0]        bit_cnt;
  logic [RXW-1:0]    rx_sr;
  logic [RXW:0]      rx_full;
  logic [7:0]        tx_sr, id_byte;
  logic [1:0]        id_idx;
  logic              src_mem;
  logic              cmd_done, addr_done, cs_exit, byte_load, load_mem, cmd_ok;

  logic              mem_active, buf_valid, discard;
  logic [7:0]        buf_q;
  logic [MEM_AW-1:0] cons_addr;

  // Pin synchronizers. CS resets high so that leaving reset never looks like a select.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sck_q     <= sck_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = ~cs_s &  sck_s & ~sck_q;
  assign sck_fall = ~cs_s & ~sck_s &  sck_q;

  assign rx_full   = {rx_sr, mosi_s};
  assign cmd_done  = (state == CMD)  && sck_rise && (bit_cnt == 5'd7);
  assign addr_done = (state == ADDR) && sck_rise && (bit_cnt == 5'd23);
  assign cs_exit   = cs_s && (state != IDLE);
  assign byte_load = (state == DATA) && sck_fall && (bit_cnt == 5'd0);
  assign load_mem  = byte_load && src_mem;
  assign cmd_ok    = (rx_full[7:0] == 8'h03) || (rx_full[7:0] == 8'h9F);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nx      = state;
    spi_miso_oe_o = (state == DATA);
    busy_o        = (state != IDLE);
    if (cs_exit) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (!cs_s) state_nx = CMD;
        CMD:     if (cmd_done) begin
                   if (rx_full[7:0] == 8'h03)      state_nx = ADDR;
                   else if (rx_full[7:0] == 8'h9F) state_nx = DATA;
                   else                            state_nx = IGNORE;
                 end
        ADDR:    if (addr_done) state_nx = DATA;
        default: ;
      endcase
    end
  end

  // Bit counter and receive shifter. The counter restarts on every state
  // change and counts rises while receiving, falls (mod 8) while sending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
    end else begin
      if (state_nx != state)
        bit_cnt <= '0;
      else if ((state == CMD || state == ADDR) && sck_rise)
        bit_cnt <= bit_cnt + 5'd1;
      else if (state == DATA && sck_fall)
        bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};

      if (state == IDLE)
        rx_sr <= '0;
      else if ((state == CMD || state == ADDR) && sck_rise)
        rx_sr <= rx_full[RXW-1:0];
    end
  end

  // ID byte for the current position: three ID bytes MSB first, then zeros.
  always_comb begin
    id_byte = 8'h00;
    case (id_idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  end

  // Transmit shifter, data source select and the error/underrun pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_sr      <= '0;
      id_idx     <= '0;
      src_mem    <= 1'b0;
      cmd_err_o  <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      cmd_err_o  <= cmd_done && !cmd_ok;
      underrun_o <= load_mem && !buf_valid;
      if (cmd_done)  src_mem <= 1'b0;
      if (addr_done) src_mem <= 1'b1;
      if (state == IDLE) begin
        tx_sr  <= '0;
        id_idx <= '0;
      end else if (byte_load) begin
        if (src_mem) begin
          tx_sr <= buf_valid ? buf_q : 8'hFF;
        end else begin
          tx_sr <= id_byte;
          if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
        end
      end else if (state == DATA && sck_fall) begin
        tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

  assign spi_miso_o = spi_miso_oe_o & tx_sr[7];

  // Memory prefetch. cons_addr is the byte the next load hands out; a valid
  // buffer always holds that byte. A request whose byte has already gone out
  // (starved load or end of transfer) is finished but its data is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      mem_active <= 1'b0;
      buf_valid  <= 1'b0;
      buf_q      <= '0;
      discard    <= 1'b0;
      cons_addr  <= '0;
    end else begin
      if (addr_done) begin
        mem_active <= 1'b1;
        buf_valid  <= 1'b0;
        cons_addr  <= rx_full[MEM_AW-1:0];
        if (!mem_req_o) begin
          mem_req_o  <= 1'b1;
          mem_addr_o <= rx_full[MEM_AW-1:0];
        end
      end
      if (cs_exit) begin
        mem_active <= 1'b0;
        buf_valid  <= 1'b0;
      end
      if (load_mem) begin
        buf_valid <= 1'b0;
        cons_addr <= cons_addr + ADDR_ONE;
        if (!mem_req_o) begin
          mem_req_o  <= 1'b1;
          mem_addr_o <= cons_addr + ADDR_ONE;
        end else if (!mem_ack_i) begin
          discard <= 1'b1;
        end
      end
      if (mem_req_o) begin
        if (mem_ack_i) begin
          mem_req_o <= 1'b0;
          discard   <= 1'b0;
          if (!discard && mem_active && !load_mem && !cs_exit) begin
            buf_q     <= mem_rdata_i;
            buf_valid <= 1'b1;
          end
        end else if (cs_exit) begin
          discard <= 1'b1;
        end
      end else if (mem_active && !buf_valid && !load_mem && !addr_done && !cs_exit) begin
        mem_req_o  <= 1'b1;
        mem_addr_o <= cons_addr;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_resp.sv
// Bench for spi_flash_resp: bit-banged SPI master, memory responder with
// programmable ack latency, and a reference model of the returned bytes.
`timescale 1ns/1ps
module tb_spi_flash_resp;
  localparam int          MEM_AW = 12;
  localparam int          MSIZE  = 1 << MEM_AW;
  localparam logic [23:0] JID    = 24'hEF4016;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              spi_clk_i = 1'b0, spi_cs_i = 1'b1, spi_mosi_i = 1'b0;
  logic              spi_miso_o, spi_miso_oe_o, mem_req_o, mem_ack_i;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [7:0]        mem_rdata_i;
  logic              busy_o, cmd_err_o, underrun_o;

  always #5 clk = ~clk;

  spi_flash_resp #(.MEM_AW(MEM_AW), .JEDEC_ID(JID), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .spi_clk_i(spi_clk_i), .spi_cs_i(spi_cs_i),
    .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .busy_o(busy_o), .cmd_err_o(cmd_err_o), .underrun_o(underrun_o)
  );

  logic [7:0]        mem [0:MSIZE-1];
  logic [7:0]        rd  [0:15];
  logic [MEM_AW-1:0] ack_log[$];
  int total = 0, bad = 0;
  int hp = 6, ack_dly = 0;
  bit ack_hold = 0;
  int n_under = 0, n_cerr = 0, inv_bad = 0;
  bit req_seen = 0, oe_seen = 0;

  // memory responder: acks after ack_dly cycles of request, one-cycle ack
  initial begin : responder
    int cnt;
    cnt = 0; mem_ack_i = 0; mem_rdata_i = 0;
    forever begin
      @(negedge clk);
      if (rst || mem_ack_i) begin
        mem_ack_i = 0; cnt = 0;
      end else if (mem_req_o) begin
        if (!ack_hold && cnt >= ack_dly) begin
          mem_ack_i = 1; mem_rdata_i = mem[mem_addr_o];
          ack_log.push_back(mem_addr_o); cnt = 0;
        end else cnt++;
      end
    end
  end

  // event monitor
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (underrun_o) n_under++;
      if (cmd_err_o) n_cerr++;
      if (mem_req_o) req_seen = 1;
      if (spi_miso_oe_o) oe_seen = 1;
      if (!spi_miso_oe_o && spi_miso_o) inv_bad++;
    end
  end

  function automatic logic [7:0] id_model(int k);
    logic [23:0] id;
    id = JID;
    if (k == 0) return id[23:16];
    if (k == 1) return id[15:8];
    if (k == 2) return id[7:0];
    return 8'h00;
  endfunction

  function automatic int addr_model(logic [23:0] a, int k);
    return (int'(a) + k) % MSIZE;
  endfunction

  task automatic fill_mem(bit pattern);
    for (int i = 0; i < MSIZE; i++)
      mem[i] = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi_i = tx[i];
      repeat (hp) @(negedge clk);
      rx = {rx[6:0], spi_miso_o};
      spi_clk_i = 1;
      repeat (hp) @(negedge clk);
      spi_clk_i = 0;
    end
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input bit with_addr, input int nrd);
    logic [7:0] dummy;
    spi_cs_i = 0;
    repeat (hp) @(negedge clk);
    spi_byte(cmd, dummy);
    if (with_addr)
      for (int b = 2; b >= 0; b--) spi_byte(addr[8*b +: 8], dummy);
    for (int k = 0; k < nrd; k++) spi_byte(8'h00, rd[k]);
    repeat (hp) @(negedge clk);
    spi_cs_i = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1; spi_cs_i = 1; spi_clk_i = 0; spi_mosi_i = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({spi_miso_o, spi_miso_oe_o, mem_req_o, busy_o, cmd_err_o, underrun_o} !== 6'b0) begin
      bad++; $display("FAIL reset_outs: got %b want 000000",
        {spi_miso_o, spi_miso_oe_o, mem_req_o, busy_o, cmd_err_o, underrun_o});
    end
    total++;
    if (mem_addr_o !== '0) begin bad++; $display("FAIL reset_addr: got %h want 000", mem_addr_o); end
    rst = 0;
    repeat (4) @(negedge clk);
    total++;
    if ({busy_o, mem_req_o} !== 2'b00) begin bad++; $display("FAIL idle_after_reset: got %b want 00", {busy_o, mem_req_o}); end
  endtask

  task automatic test_read;
    logic [23:0] a;
    a = 24'h000010; fill_mem(1); hp = 6; ack_dly = 0;
    ack_log.delete(); n_under = 0;
    xfer(8'h03, a, 1, 4);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rd[k] !== mem[addr_model(a, k)]) begin
        bad++; $display("FAIL read_byte%0d: got %h want %h", k, rd[k], mem[addr_model(a, k)]);
      end
    end
    total++;
    if (ack_log.size() < 4) begin bad++; $display("FAIL read_nreq: got %0d want >=4", ack_log.size()); end
    for (int k = 0; k < 4 && k < ack_log.size(); k++) begin
      total++;
      if (int'(ack_log[k]) != addr_model(a, k)) begin
        bad++; $display("FAIL read_addr%0d: got %h want %h", k, ack_log[k], addr_model(a, k));
      end
    end
    total++;
    if (n_under != 0) begin bad++; $display("FAIL read_underrun: got %0d want 0", n_under); end
  endtask

  task automatic test_jedec(input int n);
    req_seen = 0;
    xfer(8'h9F, 24'h0, 0, n);
    for (int k = 0; k < n; k++) begin
      total++;
      if (rd[k] !== id_model(k)) begin bad++; $display("FAIL jedec_byte%0d: got %h want %h", k, rd[k], id_model(k)); end
    end
    total++;
    if (req_seen) begin bad++; $display("FAIL jedec_memreq: got 1 want 0"); end
  endtask

  task automatic test_bad_cmd;
    n_cerr = 0; oe_seen = 0;
    xfer(8'h5A, 24'h0, 0, 2);
    total++;
    if (n_cerr != 1) begin bad++; $display("FAIL cmd_err_pulses: got %0d want 1", n_cerr); end
    total++;
    if (oe_seen) begin bad++; $display("FAIL ignore_oe: got 1 want 0"); end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL ignore_busy: got %b want 0", busy_o); end
    test_jedec(3);
  endtask

  task automatic test_wrap;
    logic [23:0] a;
    a = 24'hFFFFFE; fill_mem(0); hp = 6; ack_dly = 1;
    ack_log.delete();
    xfer(8'h03, a, 1, 4);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rd[k] !== mem[addr_model(a, k)]) begin
        bad++; $display("FAIL wrap_byte%0d: got %h want %h", k, rd[k], mem[addr_model(a, k)]);
      end
      total++;
      if (k >= ack_log.size() || int'(ack_log[k]) != addr_model(a, k)) begin
        bad++; $display("FAIL wrap_addr%0d: got %h want %h", k,
          (k < ack_log.size()) ? ack_log[k] : 12'hXXX, addr_model(a, k));
      end
    end
  endtask

  task automatic test_random;
    logic [23:0] a;
    int n;
    for (int it = 0; it < 6; it++) begin
      a = 24'($urandom); n = $urandom_range(1, 6);
      hp = $urandom_range(6, 9); ack_dly = $urandom_range(0, 2);
      n_under = 0;
      if ($urandom_range(0, 3) == 0) begin
        test_jedec(n);
      end else begin
        xfer(8'h03, a, 1, n);
        for (int k = 0; k < n; k++) begin
          total++;
          if (rd[k] !== mem[addr_model(a, k)]) begin
            bad++; $display("FAIL rand%0d_byte%0d: got %h want %h", it, k, rd[k], mem[addr_model(a, k)]);
          end
        end
        total++;
        if (n_under != 0) begin bad++; $display("FAIL rand%0d_underrun: got %0d want 0", it, n_under); end
      end
    end
  endtask

  task automatic test_underrun;
    logic [23:0] a;
    a = 24'($urandom); hp = 6; ack_dly = 40; n_under = 0;
    xfer(8'h03, a, 1, 4);
    total++;
    if (rd[0] !== 8'hFF) begin bad++; $display("FAIL starve_byte0: got %h want ff", rd[0]); end
    for (int k = 1; k < 4; k++) begin
      total++;
      if (rd[k] !== mem[addr_model(a, k)]) begin
        bad++; $display("FAIL starve_byte%0d: got %h want %h", k, rd[k], mem[addr_model(a, k)]);
      end
    end
    total++;
    if (n_under != 1) begin bad++; $display("FAIL starve_pulses: got %0d want 1", n_under); end
    ack_dly = 0;
    repeat (100) @(negedge clk);
  endtask

  task automatic test_abort;
    logic [7:0] dummy;
    logic [23:0] a;
    bit dropped;
    int w;
    hp = 6; ack_dly = 0; ack_hold = 1;
    a = 24'($urandom);
    spi_cs_i = 0;
    repeat (hp) @(negedge clk);
    spi_byte(8'h03, dummy);
    for (int b = 2; b >= 0; b--) spi_byte(a[8*b +: 8], dummy);
    for (int i = 0; i < 3; i++) begin
      spi_mosi_i = 0;
      repeat (hp) @(negedge clk); spi_clk_i = 1;
      repeat (hp) @(negedge clk); spi_clk_i = 0;
    end
    repeat (hp) @(negedge clk);
    spi_cs_i = 1;
    repeat (4) @(negedge clk);
    dropped = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!mem_req_o) dropped = 1;
    end
    total++;
    if (dropped) begin bad++; $display("FAIL abort_req_held: got dropped want held"); end
    total++;
    if ({busy_o, spi_miso_oe_o, spi_miso_o} !== 3'b000) begin
      bad++; $display("FAIL abort_idle: got %b want 000", {busy_o, spi_miso_oe_o, spi_miso_o});
    end
    ack_hold = 0;
    w = 0;
    while (mem_req_o && w < 20) begin @(negedge clk); w++; end
    total++;
    if (mem_req_o !== 1'b0) begin bad++; $display("FAIL abort_req_drop: got %b want 0", mem_req_o); end
    req_seen = 0;
    repeat (10) @(negedge clk);
    total++;
    if (req_seen) begin bad++; $display("FAIL abort_no_reissue: got 1 want 0"); end

    // second transfer, reset in the middle of the address phase
    spi_cs_i = 0;
    repeat (hp) @(negedge clk);
    spi_byte(8'h03, dummy);
    spi_byte(8'h12, dummy);
    rst = 1; spi_cs_i = 1; spi_clk_i = 0;
    @(negedge clk);
    total++;
    if ({spi_miso_o, spi_miso_oe_o, mem_req_o, busy_o, cmd_err_o, underrun_o} !== 6'b0 || mem_addr_o !== '0) begin
      bad++; $display("FAIL midreset_outs: got %b/%h want 000000/000",
        {spi_miso_o, spi_miso_oe_o, mem_req_o, busy_o, cmd_err_o, underrun_o}, mem_addr_o);
    end
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    total++;
    if ({mem_req_o, busy_o} !== 2'b00) begin bad++; $display("FAIL postreset_idle: got %b want 00", {mem_req_o, busy_o}); end
    a = 24'($urandom);
    xfer(8'h03, a, 1, 3);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rd[k] !== mem[addr_model(a, k)]) begin
        bad++; $display("FAIL postreset_byte%0d: got %h want %h", k, rd[k], mem[addr_model(a, k)]);
      end
    end
  endtask

  task automatic test_miso_quiet;
    total++;
    if (inv_bad != 0) begin bad++; $display("FAIL miso_when_oe_low: got %0d cycles want 0", inv_bad); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_jedec(5);
    test_bad_cmd();
    test_wrap();
    test_random();
    test_underrun();
    test_abort();
    test_miso_quiet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_flash_resp.md
Name: spi_flash_resp

Overview:
- SPI-flash responder (target side) for the SoC's single-SPI flash master interface (clk/cs/mosi/miso).
- Used as an on-chip/FPGA flash model and as the bench responder for the master.
- Oversamples the SPI pins in the system clock domain and decodes READ (0x03) and JEDEC-ID (0x9F).
- Streams data bytes fetched from a byte-wide memory read port.

Parameters:
MEM_AW, 12, byte-address width forwarded to memory; upper flash address bits ignored
JEDEC_ID, 24'hEF4016, 3-byte ID returned by 0x9F, MSB byte first
SYNC_STAGES, 2, synchronizer depth on spi_clk_i/spi_cs_i/spi_mosi_i (>=2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
spi_clk_i  in  1  SPI SCK, mode 0
spi_cs_i  in  1  chip select, active low
spi_mosi_i  in  1  serial data from master
spi_miso_o  out  1  serial data to master
spi_miso_oe_o  out  1  MISO drive enable
mem_req_o  out  1  memory read request
mem_addr_o  out  MEM_AW  memory byte address
mem_rdata_i  in  8  read data, valid when mem_ack_i=1
mem_ack_i  in  1  read acknowledge
busy_o  out  1  CS asserted (synchronized)
cmd_err_o  out  1  1-cycle pulse: unsupported command
underrun_o  out  1  1-cycle pulse: data byte needed before memory returned

Behaviour:
- Reset: all outputs 0; FSM=IDLE; counters, shift registers and prefetch buffer cleared; buffer-valid=0.
- Synchronization and edge detect:
  - All three SPI inputs pass through SYNC_STAGES flops.
  - Rise/fall of SCK is detected from the last two synchronized samples.
  - Requirement on SCK: each half-period >= SYNC_STAGES+2 clk_i cycles.
  - Edges are ignored while CS is high.
- Mode 0: MOSI sampled on synchronized SCK rise; MISO updated on synchronized SCK fall. Bits are MSB first.
- FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE -> CMD on CS fall. Bit counter cleared; busy_o=1.
  - CMD: shift 8 bits. On the 8th rise:
    - 0x03 -> ADDR.
    - 0x9F -> DATA with ID source.
    - Any other value -> IGNORE, and cmd_err_o pulses for 1 cycle.
  - ADDR: shift 24 bits. On the 24th rise: mem_addr_o = addr[MEM_AW-1:0], mem_req_o asserted in the next cycle, then -> DATA with memory source.
  - DATA:
    - On each SCK fall with bit count=0: load the TX shift register from the source and drive bit7.
    - On each other SCK fall: shift left.
    - spi_miso_oe_o=1 throughout DATA.
  - IGNORE: miso_oe=0 until CS rises.
  - Any state: CS rise -> IDLE next cycle; miso_oe_o=0; spi_miso_o=0; busy_o=0.
- ID source: bytes ID[23:16], ID[15:8], ID[7:0], then 0x00 for every further byte.
- Memory source (prefetch buffer, 1 byte):
  - mem_req_o stays high until the cycle mem_ack_i=1. On that cycle, mem_rdata_i is captured into the buffer and buffer-valid=1.
  - mem_req_o drops the following cycle.
  - At each byte load: buffer is consumed and buffer-valid=0.
  - After the load, mem_addr_o increments, wrapping 2^MEM_AW-1 -> 0, and a new request issues next cycle.
  - Load with buffer-valid=0: shift register loads 0xFF, underrun_o pulses, and the address still increments.
- Outstanding request at CS rise:
  - mem_req_o is held until ack; the handshake is never abandoned.
  - The acked data is discarded.
  - A new transaction's request is issued only after that ack.
- Reset mid-operation: immediate return to reset values, including mem_req_o=0.
- spi_miso_o=0 whenever spi_miso_oe_o=0.

Test Plan:
1. READ 0x03, addr 0x000010, memory returns addr[7:0]^0x5A with 1-cycle ack, SCK half-period 6 clk -> master reads 4 bytes 0x4A,0x4B,0x48,0x49; mem_addr_o sequence 0x010..0x013; no underrun.
2. JEDEC 0x9F, 5 bytes clocked -> EF,40,16,00,00; mem_req_o never asserted.
3. Command 0x5A -> cmd_err_o single pulse after 8th rise; miso_oe_o stays 0; CS rise -> busy_o=0, next 0x9F transaction correct.
4. READ at addr 0xFFFFFE (MEM_AW=12) -> mem_addr_o 0xFFE,0xFFF,0x000,0x001; bytes match memory at those addresses.
5. READ with mem_ack_i delayed 40 cycles, SCK half-period 6 clk -> first byte 0xFF with one underrun_o pulse per starved byte; later bytes valid once acks arrive.
6. CS raised after 3 data bits with request outstanding; ack arrives 10 cycles later; rst_i pulsed mid-ADDR in a second transfer -> mem_req_o held until ack then drops, data unused; after reset, all outputs 0 and a fresh READ succeeds.
